// File: rtl/timing_viol_logger_if.sv
// Event-record drain port of the timing violation logger.
// Master drives valid + head record; slave drives ready.
interface timing_viol_logger_if #(
    parameter int NUM_SIG = 2,
    parameter int TS_W    = 16
);
    logic               evt_valid;
    logic               evt_ready;
    logic [NUM_SIG-1:0] evt_setup;
    logic [NUM_SIG-1:0] evt_hold;
    logic [TS_W-1:0]    evt_ts;

    modport master (
        output evt_valid,
        output evt_setup,
        output evt_hold,
        output evt_ts,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_setup,
        input  evt_hold,
        input  evt_ts,
        output evt_ready
    );
endinterface

// File: rtl/timing_viol_logger.sv
// Timing violation logger: saturating per-signal setup/hold counters
// plus an event FIFO of violation records drained over valid/ready.
// Ports: i_clk, i_rst (sync, active-high), i_setup_viol/i_hold_viol
// strobes, i_clr_cnt, evt (record drain, master), o_setup_cnt,
// o_hold_cnt, o_fifo_level, o_overflow, o_drop_cnt.
// Macro TIMING_VIOL_LOGGER_TS_EN: build the cycle timestamp counter and
// store it per record; otherwise evt_ts is tied to zero.
module timing_viol_logger #(
    parameter int NUM_SIG = 2,
    parameter int DEPTH   = 8,
    parameter int TS_W    = 16,
    parameter int CNT_W   = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_SIG-1:0]       i_setup_viol,
    input  logic [NUM_SIG-1:0]       i_hold_viol,
    input  logic                     i_clr_cnt,
    timing_viol_logger_if.master     evt,
    output logic [NUM_SIG*CNT_W-1:0] o_setup_cnt,
    output logic [NUM_SIG*CNT_W-1:0] o_hold_cnt,
    output logic [$clog2(DEPTH):0]   o_fifo_level,
    output logic                     o_overflow,
    output logic [CNT_W-1:0]         o_drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]          r_wptr;
    logic [AW:0]          r_rptr;
    logic [NUM_SIG-1:0]   r_mem_s [DEPTH];
    logic [NUM_SIG-1:0]   r_mem_h [DEPTH];
    logic [CNT_W-1:0]     r_scnt [NUM_SIG];
    logic [CNT_W-1:0]     r_hcnt [NUM_SIG];
    logic [CNT_W-1:0]     r_drop;
    logic                 r_ovf;

    logic w_empty;
    logic w_full;
    logic w_push_req;
    logic w_pop;
    logic w_push_ok;
    logic w_drop;

    assign w_empty    = (r_wptr == r_rptr);
    // Same index, opposite lap bit: writer is a full lap ahead.
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) &&
                        (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push_req = (|i_setup_viol) | (|i_hold_viol);
    assign w_pop      = !w_empty && evt.evt_ready;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign w_push_ok  = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            if (w_pop)     r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push_ok) begin
            r_mem_s[r_wptr[AW-1:0]] <= i_setup_viol;
            r_mem_h[r_wptr[AW-1:0]] <= i_hold_viol;
        end
    end

    // Payload is masked while empty so stale entries never show.
    assign evt.evt_valid = !w_empty;
    assign evt.evt_setup = w_empty ? '0 : r_mem_s[r_rptr[AW-1:0]];
    assign evt.evt_hold  = w_empty ? '0 : r_mem_h[r_rptr[AW-1:0]];
    assign o_fifo_level  = r_wptr - r_rptr;

`ifdef TIMING_VIOL_LOGGER_TS_EN
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_mem_ts [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) r_ts <= '0;
        else       r_ts <= r_ts + {{(TS_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push_ok) r_mem_ts[r_wptr[AW-1:0]] <= r_ts;
    end

    assign evt.evt_ts = w_empty ? '0 : r_mem_ts[r_rptr[AW-1:0]];
`else
    assign evt.evt_ts = {TS_W{1'b0}};
`endif

    // Clear wins over same-cycle increments; the record path is separate.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr_cnt) begin
            for (int i = 0; i < NUM_SIG; i++) begin
                r_scnt[i] <= '0;
                r_hcnt[i] <= '0;
            end
            r_drop <= '0;
            r_ovf  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SIG; i++) begin
                if (i_setup_viol[i] && !(&r_scnt[i]))
                    r_scnt[i] <= r_scnt[i] + CNT_W'(1);
                if (i_hold_viol[i] && !(&r_hcnt[i]))
                    r_hcnt[i] <= r_hcnt[i] + CNT_W'(1);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (!(&r_drop)) r_drop <= r_drop + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_SIG; g++) begin : g_pack
        assign o_setup_cnt[g*CNT_W +: CNT_W] = r_scnt[g];
        assign o_hold_cnt[g*CNT_W +: CNT_W]  = r_hcnt[g];
    end

    assign o_overflow = r_ovf;
    assign o_drop_cnt = r_drop;
endmodule

// File: tb/tb_timing_viol_logger.sv
// Scoreboard bench for timing_viol_logger: a reference model tracks
// records, counters and drops; DUT state is compared every cycle.
module tb_timing_viol_logger;
    localparam int NS = 2;
    localparam int DP = 8;
    localparam int TW = 16;
    localparam int CW = 8;

    typedef struct packed {
        logic [NS-1:0] s;
        logic [NS-1:0] h;
        logic [TW-1:0] ts;
    } rec_t;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [NS-1:0] i_setup_viol = '0;
    logic [NS-1:0] i_hold_viol = '0;
    logic          i_clr_cnt = 1'b0;
    logic [NS*CW-1:0] o_setup_cnt;
    logic [NS*CW-1:0] o_hold_cnt;
    logic [$clog2(DP):0] o_fifo_level;
    logic          o_overflow;
    logic [CW-1:0] o_drop_cnt;

    timing_viol_logger_if #(.NUM_SIG(NS), .TS_W(TW)) bus ();

    timing_viol_logger #(
        .NUM_SIG(NS), .DEPTH(DP), .TS_W(TW), .CNT_W(CW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_setup_viol (i_setup_viol),
        .i_hold_viol  (i_hold_viol),
        .i_clr_cnt    (i_clr_cnt),
        .evt          (bus.master),
        .o_setup_cnt  (o_setup_cnt),
        .o_hold_cnt   (o_hold_cnt),
        .o_fifo_level (o_fifo_level),
        .o_overflow   (o_overflow),
        .o_drop_cnt   (o_drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    rec_t          q[$];
    logic [CW-1:0] m_s [NS];
    logic [CW-1:0] m_h [NS];
    logic [CW-1:0] m_drop;
    logic          m_ovf;
    logic [TW-1:0] m_ts;
    bit            m_init = 0;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model(input logic [NS-1:0] s, input logic [NS-1:0] h,
                         input logic clr, input logic rdy, input logic r);
        rec_t rec;
        if (m_init) begin
            check("valid", 32'(bus.evt_valid), 32'(q.size() != 0));
            check("level", 32'(o_fifo_level), 32'(q.size()));
            check("ovf", 32'(o_overflow), 32'(m_ovf));
            check("drop", 32'(o_drop_cnt), 32'(m_drop));
            check("scnt", 32'(o_setup_cnt), 32'({m_s[1], m_s[0]}));
            check("hcnt", 32'(o_hold_cnt), 32'({m_h[1], m_h[0]}));
            if (q.size() != 0) begin
                check("evt_s", 32'(bus.evt_setup), 32'(q[0].s));
                check("evt_h", 32'(bus.evt_hold), 32'(q[0].h));
                check("evt_ts", 32'(bus.evt_ts), 32'(q[0].ts));
            end
        end
        if (r) begin
            q.delete();
            for (int i = 0; i < NS; i++) begin
                m_s[i] = '0;
                m_h[i] = '0;
            end
            m_drop = '0;
            m_ovf  = 1'b0;
            m_ts   = '0;
            m_init = 1;
            return;
        end
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if ((|s) || (|h)) begin
            rec.s = s;
            rec.h = h;
`ifdef TIMING_VIOL_LOGGER_TS_EN
            rec.ts = m_ts;
`else
            rec.ts = '0;
`endif
            if (q.size() < DP) begin
                q.push_back(rec);
            end else if (!clr) begin
                m_ovf = 1'b1;
                if (m_drop != '1) m_drop++;
            end
        end
        if (clr) begin
            for (int i = 0; i < NS; i++) begin
                m_s[i] = '0;
                m_h[i] = '0;
            end
            m_drop = '0;
            m_ovf  = 1'b0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (s[i] && m_s[i] != '1) m_s[i]++;
                if (h[i] && m_h[i] != '1) m_h[i]++;
            end
        end
        m_ts++;
    endtask

    task automatic cyc(input logic [NS-1:0] s, input logic [NS-1:0] h,
                       input logic clr = 1'b0, input logic rdy = 1'b0,
                       input logic r = 1'b0);
        i_setup_viol  = s;
        i_hold_viol   = h;
        i_clr_cnt     = clr;
        bus.evt_ready = rdy;
        i_rst         = r;
        @(negedge clk);
        model(s, h, clr, rdy, r);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.evt_ready = 1'b0;
        repeat (3) cyc(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        repeat (5) cyc(2'b00, 2'b00);
        cyc(2'b01, 2'b00);
        cyc(2'b00, 2'b00);
        check("first_lvl", 32'(o_fifo_level), 32'd1);
        cyc(2'b00, 2'b00, 1'b0, 1'b1);
        cyc(2'b10, 2'b11);
        cyc(2'b00, 2'b00);
        check("combo_lvl", 32'(o_fifo_level), 32'd1);
        cyc(2'b00, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cyc(2'(i % 3 + 1), 2'b00);
        cyc(2'b00, 2'b00);
        check("full_lvl", 32'(o_fifo_level), 32'd8);
        check("full_drop", 32'(o_drop_cnt), 32'd2);
        cyc(2'b01, 2'b10, 1'b0, 1'b1);
        cyc(2'b00, 2'b00);
        check("fullpop_lvl", 32'(o_fifo_level), 32'd8);
        check("fullpop_drop", 32'(o_drop_cnt), 32'd2);
        repeat (10) cyc(2'b00, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) cyc(2'b00, 2'b01, 1'b0, 1'b1);
        cyc(2'b00, 2'b00);
        check("hsat", 32'(o_hold_cnt[CW-1:0]), 32'd255);
        cyc(2'b00, 2'b01, 1'b1, 1'b1);
        cyc(2'b00, 2'b00);
        check("clr_h", 32'(o_hold_cnt[CW-1:0]), 32'd0);
        check("clr_ovf", 32'(o_overflow), 32'd0);
        for (int i = 0; i < 250; i++) begin
            logic [NS-1:0] s;
            logic [NS-1:0] h;
            s = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            h = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            cyc(s, h, ($urandom_range(0, 40) == 0),
                ($urandom_range(0, 3) != 0));
        end
        repeat (10) cyc(2'b00, 2'b00, 1'b0, 1'b1);
        repeat (3) cyc(2'b11, 2'b01);
        cyc(2'b10, 2'b10, 1'b0, 1'b0, 1'b1);
        cyc(2'b00, 2'b00);
        check("rst_valid", 32'(bus.evt_valid), 32'd0);
        check("rst_lvl", 32'(o_fifo_level), 32'd0);
        repeat (2) cyc(2'b00, 2'b00);
        cyc(2'b01, 2'b01);
        repeat (3) cyc(2'b00, 2'b00, 1'b0, 1'b1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
